register_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the internal 32-bit register bus of `motion_system`. It serves NOS_REQ requesters, e.g. the uP byte-handshake command interpreter and an on-chip scheduler. Each requester posts a single read or write of one register (8-bit address, 32-bit data). The block grants the bus to one requester, runs one strobe/acknowledge transaction against the PWM, QE and RC-servo subsystems, and returns read data plus a 32-bit status word.

---
 rtl/register_bus_arbiter_if.sv | 37 +++
 rtl/register_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_register_bus_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/register_bus_arbiter_if.sv
// Register bus arbiter interface: requester side and subsystem bus side.
//
// Handshake: a requester holds req[i] high (level) with req_RW/req_addr/req_data
// stable until the arbiter samples it in IDLE; the request is then owned by the
// arbiter, grant[i] stays high from STROBE through DONE, and done[i] pulses for
// exactly one cycle with rd_data/status valid. On the bus side bus_strobe is a
// one-cycle start; the subsystem answers with bus_ack (bus_data_in valid with it).
interface register_bus_arbiter_if #(
  parameter int NOS_REQ = 2
) ();
  logic [NOS_REQ-1:0]    req;
  logic [NOS_REQ-1:0]    req_RW;
  logic [NOS_REQ*8-1:0]  req_addr;
  logic [NOS_REQ*32-1:0] req_data;
  logic [NOS_REQ-1:0]    grant;
  logic [NOS_REQ-1:0]    done;
  logic [31:0]           rd_data;
  logic [31:0]           status;
  logic [7:0]            bus_addr;
  logic [31:0]           bus_data_out;
  logic                  bus_RW;
  logic                  bus_strobe;
  logic                  bus_ack;
  logic [31:0]           bus_data_in;

  // Arbiter view
  modport master (
    input  req, req_RW, req_addr, req_data, bus_ack, bus_data_in,
    output grant, done, rd_data, status, bus_addr, bus_data_out, bus_RW, bus_strobe
  );

  // Requesters plus subsystems view
  modport slave (
    output req, req_RW, req_addr, req_data, bus_ack, bus_data_in,
    input  grant, done, rd_data, status, bus_addr, bus_data_out, bus_RW, bus_strobe
  );
endinterface

// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter and sequencer for the 32-bit internal register bus.
// One requester at a time gets a single strobe/ack transaction; a bus timeout
// returns zero data with status[0] set.
module register_bus_arbiter #(
  parameter int NOS_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  register_bus_arbiter_if.master bif,
  output logic [1:0]             dbg_state,
  output logic [2:0]             dbg_ptr
);

  localparam int PTR_W = (NOS_REQ > 1) ? $clog2(NOS_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [7:0]           timer_q, timer_d;
  logic [NOS_REQ-1:0]   grant_q, grant_d;
  logic [NOS_REQ-1:0]   done_q, done_d;
  logic                 strobe_q, strobe_d;
  logic                 bus_rw_q, bus_rw_d;
  logic [7:0]           bus_addr_q, bus_addr_d;
  logic [31:0]          bus_wdata_q, bus_wdata_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic [31:0]          status_q, status_d;

  logic                 any_req;
  logic                 hi_found;
  logic [PTR_W-1:0]     hi_idx;
  logic [PTR_W-1:0]     lo_idx;
  logic [PTR_W-1:0]     win_idx;
  logic [2:0]           win3;
  logic [2:0]           ptr3;
  logic [31:0]          status_base;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap)
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NOS_REQ - 1; i >= 0; i--) begin
      if (bif.req[i]) begin
        any_req = 1'b1;
        lo_idx  = PTR_W'(i);
        if (PTR_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Zero-extended indices and the status word fields known before completion
  always_comb begin
    win3              = '0;
    win3[PTR_W-1:0]   = win_q;
    ptr3              = '0;
    ptr3[PTR_W-1:0]   = ptr_q;
    status_base       = '0;
    status_base[1]    = bus_rw_q;
    status_base[15:8] = bus_addr_q;
    status_base[18:16] = win3;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    timer_d     = timer_q;
    grant_d     = grant_q;
    done_d      = '0;
    strobe_d    = 1'b0;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          bus_rw_d         = bif.req_RW[win_idx];
          bus_addr_d       = bif.req_addr[{win_idx, 3'b000} +: 8];
          bus_wdata_d      = bif.req_data[{win_idx, 5'b00000} +: 32];
          strobe_d         = 1'b1;
          state_d          = S_STROBE;
        end
      end
      S_STROBE: begin
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An ack on the same cycle the timer expires still wins
        if (bif.bus_ack) begin
          rd_data_d = bus_rw_q ? bus_wdata_q : bif.bus_data_in;
          status_d  = status_base;
          done_d    = grant_q;
          state_d   = S_DONE;
        end else if (timer_q == 8'(TIMEOUT_CYCLES)) begin
          rd_data_d = '0;
          status_d  = status_base | 32'h1;
          done_d    = grant_q;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        ptr_d   = (win_q == PTR_W'(NOS_REQ - 1)) ? '0 : win_q + 1'b1;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      timer_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      strobe_q    <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      timer_q     <= timer_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      strobe_q    <= strobe_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
      status_q    <= status_d;
    end
  end

  assign bif.grant        = grant_q;
  assign bif.done         = done_q;
  assign bif.rd_data      = rd_data_q;
  assign bif.status       = status_q;
  assign bif.bus_addr     = bus_addr_q;
  assign bif.bus_data_out = bus_wdata_q;
  assign bif.bus_RW       = bus_rw_q;
  assign bif.bus_strobe   = strobe_q;
  assign dbg_state        = state_q;
  assign dbg_ptr          = ptr3;

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Directed testbench for register_bus_arbiter (NOS_REQ = 2, TIMEOUT_CYCLES = 16).
module tb_register_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [2:0] dbg_ptr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Subsystem responder control: ack on WAIT_ACK cycle (ack_delay + 1); -1 = never
  int          ack_delay = -1;
  logic [31:0] ack_data  = '0;

  register_bus_arbiter_if #(.NOS_REQ(2)) bif ();

  register_bus_arbiter #(
    .NOS_REQ        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bif       (bif),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Subsystem responder: watches for bus_strobe and acks after ack_delay WAIT_ACK cycles
  initial begin
    bif.bus_ack     = 1'b0;
    bif.bus_data_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bif.bus_strobe && ack_delay >= 0) begin
        repeat (ack_delay + 1) @(posedge clk);
        #2;
        bif.bus_ack     = 1'b1;
        bif.bus_data_in = ack_data;
        @(posedge clk);
        #2;
        bif.bus_ack     = 1'b0;
        bif.bus_data_in = '0;
      end
    end
  end

  // One request from requester 'who', checked from strobe through done and back to IDLE
  task automatic do_txn(input string tag, input int who, input logic rw,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input int dly, input logic [31:0] rdata, input int lat,
                        input logic [31:0] exp_rd, input logic [31:0] exp_status);
    logic [1:0] onehot;
    onehot      = (who == 0) ? 2'b01 : 2'b10;
    ack_delay   = dly;
    ack_data    = rdata;
    bif.req     = onehot;
    bif.req_RW[who] = rw;
    bif.req_addr[who*8 +: 8]   = addr;
    bif.req_data[who*32 +: 32] = wdata;
    tick();
    check({tag, " strobe"}, 32'(bif.bus_strobe), 32'd1);
    check({tag, " grant"}, 32'(bif.grant), 32'(onehot));
    check({tag, " bus_addr"}, 32'(bif.bus_addr), 32'(addr));
    check({tag, " bus_RW"}, 32'(bif.bus_RW), 32'(rw));
    bif.req = 2'b00;
    for (int c = 2; c < lat; c++) begin
      tick();
      check({tag, " done early"}, 32'(bif.done), 32'd0);
    end
    tick();
    check({tag, " done"}, 32'(bif.done), 32'(onehot));
    check({tag, " rd_data"}, bif.rd_data, exp_rd);
    check({tag, " status"}, bif.status, exp_status);
    tick();
    check({tag, " done cleared"}, 32'(bif.done), 32'd0);
    check({tag, " grant cleared"}, 32'(bif.grant), 32'd0);
    check({tag, " idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bif.req      = '0;
    bif.req_RW   = '0;
    bif.req_addr = '0;
    bif.req_data = '0;

    // Reset values
    tick();
    tick();
    check("rst grant", 32'(bif.grant), 32'd0);
    check("rst done", 32'(bif.done), 32'd0);
    check("rst strobe", 32'(bif.bus_strobe), 32'd0);
    check("rst bus_addr", 32'(bif.bus_addr), 32'd0);
    check("rst bus_data_out", bif.bus_data_out, 32'd0);
    check("rst rd_data", bif.rd_data, 32'd0);
    check("rst status", bif.status, 32'd0);
    check("rst ptr", 32'(dbg_ptr), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Single write, immediate ack: done at req+3
    do_txn("wr0", 0, 1'b1, 8'h11, 32'h12345678, 0, 32'hFFFF0000, 3,
           32'h12345678, 32'h00001102);
    check("wr0 ptr", 32'(dbg_ptr), 32'd1);

    // Delayed read by requester 1: ack on 6th WAIT_ACK cycle, done at req+8
    do_txn("rd1", 1, 1'b0, 8'h20, 32'h0, 5, 32'hDEADBEEF, 8,
           32'hDEADBEEF, 32'h00012000);
    check("rd1 ptr", 32'(dbg_ptr), 32'd0);

    // Round-robin: both requesters hold req for four transactions
    ack_delay    = 0;
    ack_data     = '0;
    bif.req_RW   = 2'b11;
    bif.req_addr = {8'h31, 8'h30};
    bif.req_data = {32'hA1A1A1A1, 32'hA0A0A0A0};
    bif.req      = 2'b11;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (cyc % 4 == 1) begin
        check("rr strobe", 32'(bif.bus_strobe), 32'd1);
        check("rr bus_addr", 32'(bif.bus_addr), ((cyc / 4) % 2 == 0) ? 32'h30 : 32'h31);
      end
      if (cyc % 4 == 3)
        check("rr done", 32'(bif.done), ((cyc / 4) % 2 == 0) ? 32'd1 : 32'd2);
      else
        check("rr no done", 32'(bif.done), 32'd0);
      if (cyc == 15) begin
        check("rr last rd_data", bif.rd_data, 32'hA1A1A1A1);
        check("rr last status", bif.status, 32'h00013102);
        bif.req = 2'b00;
      end
    end
    tick();
    check("rr idle", 32'(dbg_state), 32'd0);
    check("rr ptr", 32'(dbg_ptr), 32'd0);

    // Timeout: no ack, done at req+19, zero data and status[0] set
    do_txn("tmo", 0, 1'b0, 8'h05, 32'h0, -1, 32'h0, 19,
           32'h00000000, 32'h00000501);

    // Ack on 16th WAIT_ACK cycle: ack wins
    do_txn("bnd16", 1, 1'b0, 8'h40, 32'h0, 15, 32'hCAFEF00D, 18,
           32'hCAFEF00D, 32'h00014000);

    // Ack on the final (17th) WAIT_ACK cycle, same cycle the timer expires: ack wins
    do_txn("bnd17", 0, 1'b0, 8'h41, 32'h0, 16, 32'h0BADF00D, 19,
           32'h0BADF00D, 32'h00004100);
    check("bnd17 ptr", 32'(dbg_ptr), 32'd1);

    // Reset during WAIT_ACK
    ack_delay        = -1;
    bif.req          = 2'b01;
    bif.req_RW       = 2'b01;
    bif.req_addr     = {8'h00, 8'h66};
    bif.req_data     = {32'h0, 32'h77777777};
    tick();
    bif.req = 2'b00;
    tick();
    tick();
    check("mid state", 32'(dbg_state), 32'd2);
    check("mid ptr", 32'(dbg_ptr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst grant", 32'(bif.grant), 32'd0);
    check("mrst done", 32'(bif.done), 32'd0);
    check("mrst strobe", 32'(bif.bus_strobe), 32'd0);
    check("mrst bus_RW", 32'(bif.bus_RW), 32'd0);
    check("mrst bus_addr", 32'(bif.bus_addr), 32'd0);
    check("mrst bus_data_out", bif.bus_data_out, 32'd0);
    check("mrst rd_data", bif.rd_data, 32'd0);
    check("mrst status", bif.status, 32'd0);
    check("mrst ptr", 32'(dbg_ptr), 32'd0);
    check("mrst state", 32'(dbg_state), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("post rst no done", 32'(bif.done), 32'd0);
      check("post rst no strobe", 32'(bif.bus_strobe), 32'd0);
    end

    // Later request from requester 1 completes normally
    do_txn("post", 1, 1'b1, 8'h7F, 32'h55AA55AA, 0, 32'h0, 3,
           32'h55AA55AA, 32'h00017F02);
    check("post ptr", 32'(dbg_ptr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
